// File: rtl/fetch_stage_if.sv
// Fetch-to-memory and fetch-to-decode signal bundle for fetch_stage.
// The master modport is the fetch stage; the slave modport is its environment.
interface fetch_stage_if;
   logic [31:0] imem_a;
   logic [31:0] imem_rd;
   logic        redirect;
   logic [31:0] redirect_pc;
   logic        valid_d;
   logic        ready_d;
   logic [31:0] instr_d;
   logic [31:0] pc_d;
   logic [31:0] pcplus8_d;

   // Handshake: an entry transfers to decode on a rising edge where valid_d && ready_d;
   // valid_d never depends on ready_d, and once raised it holds with stable
   // instr_d/pc_d until the transfer, unless a redirect or reset flushes the entry.
   modport master (
      output imem_a,
      input  imem_rd,
      input  redirect,
      input  redirect_pc,
      output valid_d,
      input  ready_d,
      output instr_d,
      output pc_d,
      output pcplus8_d
   );

   modport slave (
      input  imem_a,
      output imem_rd,
      output redirect,
      output redirect_pc,
      input  valid_d,
      output ready_d,
      input  instr_d,
      input  pc_d,
      input  pcplus8_d
   );
endinterface

// File: rtl/fetch_stage.sv
// Instruction fetch: owns the PC, reads instruction memory combinationally and
// queues {instr, pc} pairs in a 2-entry buffer presented to decode.
module fetch_stage #(
   parameter logic [31:0] RESET_PC = 32'h0000_0000,
   parameter int          DEPTH    = 2
) (
   input  logic          clk,
   input  logic          reset_n,
   fetch_stage_if.master bus,
   output logic [1:0]    count
);

   logic [31:0] pc_f;
   logic [31:0] buf_instr [2];
   logic [31:0] buf_pc    [2];
   logic        head;
   logic [1:0]  cnt;
   logic [31:0] last_instr;
   logic [31:0] last_pc;

   logic        valid;
   logic        pop;
   logic        push;
   logic        tail;
   logic [31:0] instr_out;
   logic [31:0] pc_out;
   logic        unused_bits;

   assign valid = (cnt != 2'd0);
   assign pop   = valid && bus.ready_d;
   assign push  = !bus.redirect && ((cnt != 2'd2) || pop);

   // With one entry the free slot is the other one; when empty, or full and
   // popping, the slot under head is the one being refilled.
   assign tail = (cnt == 2'd1) ? ~head : head;

   assign instr_out = valid ? buf_instr[head] : last_instr;
   assign pc_out    = valid ? buf_pc[head]    : last_pc;

   assign bus.imem_a    = pc_f;
   assign bus.valid_d   = valid;
   assign bus.instr_d   = instr_out;
   assign bus.pc_d      = pc_out;
   assign bus.pcplus8_d = pc_out + 32'd8;
   assign count         = cnt;

   assign unused_bits = ^bus.redirect_pc[1:0];

   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         pc_f       <= RESET_PC;
         cnt        <= 2'd0;
         head       <= 1'b0;
         last_instr <= 32'd0;
         last_pc    <= 32'd0;
      end else begin
         // Mirror the presented word so the outputs freeze once the buffer drains.
         last_instr <= instr_out;
         last_pc    <= pc_out;
         head       <= head ^ pop;
         if (bus.redirect) begin
            cnt  <= 2'd0;
            pc_f <= {bus.redirect_pc[31:2], 2'b00};
         end else begin
            cnt <= cnt + {1'b0, push} - {1'b0, pop};
            if (push) begin
               pc_f <= pc_f + 32'd4;
            end
         end
      end
   end

   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         for (int i = 0; i < 2; i++) begin
            buf_instr[i] <= 32'd0;
            buf_pc[i]    <= 32'd0;
         end
      end else if (push) begin
         buf_instr[tail] <= bus.imem_rd;
         buf_pc[tail]    <= pc_f;
      end
   end

endmodule

// File: tb/tb_fetch_stage.sv
// Directed bench for fetch_stage: startup, backpressure, redirects, async reset
// and PC wrap-around, checked with immediate assertions.
module tb_fetch_stage;

   logic       clk;
   logic       reset_n;
   logic       reset_n_b;
   logic [1:0] count_a;
   logic [1:0] count_b;

   int compared;
   int mismatched;

   fetch_stage_if bus_a ();
   fetch_stage_if bus_b ();

   fetch_stage #(.RESET_PC(32'h0000_0000), .DEPTH(2)) dut_a (
      .clk     (clk),
      .reset_n (reset_n),
      .bus     (bus_a),
      .count   (count_a)
   );

   fetch_stage #(.RESET_PC(32'hFFFF_FFF8), .DEPTH(2)) dut_b (
      .clk     (clk),
      .reset_n (reset_n_b),
      .bus     (bus_b),
      .count   (count_b)
   );

   function automatic logic [31:0] mem_word(input logic [31:0] a);
      case (a)
         32'h0000_0000: mem_word = 32'hE3A0_1002;
         32'h0000_0004: mem_word = 32'hE3A0_2003;
         32'h0000_0008: mem_word = 32'hE1A0_3211;
         default:       mem_word = 32'hA000_0000 | a;
      endcase
   endfunction

   assign bus_a.imem_rd = mem_word(bus_a.imem_a);
   assign bus_b.imem_rd = mem_word(bus_b.imem_a);

   initial begin
      clk = 1'b0;
      forever #5 clk = ~clk;
   end

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic check(input string tag, input logic [31:0] observed, input logic [31:0] expected);
      compared++;
      assert (observed === expected)
      else begin
         mismatched++;
         $error("FAIL %s observed=%h expected=%h", tag, observed, expected);
      end
   endtask

   initial begin
      compared   = 0;
      mismatched = 0;
      reset_n    = 1'b1;
      reset_n_b  = 1'b1;
      bus_a.ready_d     = 1'b1;
      bus_a.redirect    = 1'b0;
      bus_a.redirect_pc = 32'd0;
      bus_b.ready_d     = 1'b1;
      bus_b.redirect    = 1'b0;
      bus_b.redirect_pc = 32'd0;
      #2;
      reset_n   = 1'b0;
      reset_n_b = 1'b0;
      tick();
      tick();

      // reset values
      check("rst_imem_a", bus_a.imem_a, 32'h0);
      check("rst_count", {30'd0, count_a}, 32'd0);
      check("rst_valid", {31'd0, bus_a.valid_d}, 32'd0);
      check("rst_instr", bus_a.instr_d, 32'h0);
      check("rst_pc", bus_a.pc_d, 32'h0);
      check("rst_pc8", bus_a.pcplus8_d, 32'h8);

      // startup stream
      reset_n = 1'b1;
      tick();
      check("start0_valid", {31'd0, bus_a.valid_d}, 32'd1);
      check("start0_instr", bus_a.instr_d, 32'hE3A0_1002);
      check("start0_pc", bus_a.pc_d, 32'h0);
      check("start0_pc8", bus_a.pcplus8_d, 32'h8);
      tick();
      check("start1_instr", bus_a.instr_d, 32'hE3A0_2003);
      check("start1_pc", bus_a.pc_d, 32'h4);
      check("start1_count", {30'd0, count_a}, 32'd1);
      tick();
      check("start2_instr", bus_a.instr_d, 32'hE1A0_3211);
      check("start2_pc", bus_a.pc_d, 32'h8);
      check("start2_pc8", bus_a.pcplus8_d, 32'h10);

      // backpressure after the first pop
      reset_n = 1'b0;
      tick();
      reset_n = 1'b1;
      tick();
      check("bp_first_pc", bus_a.pc_d, 32'h0);
      tick();
      check("bp_second_pc", bus_a.pc_d, 32'h4);
      bus_a.ready_d = 1'b0;
      for (int i = 0; i < 3; i++) begin
         tick();
         check("bp_count", {30'd0, count_a}, 32'd2);
         check("bp_imem_a", bus_a.imem_a, 32'hC);
         check("bp_valid", {31'd0, bus_a.valid_d}, 32'd1);
         check("bp_instr", bus_a.instr_d, 32'hE3A0_2003);
      end
      bus_a.ready_d = 1'b1;
      tick();
      check("bp_resume0_instr", bus_a.instr_d, 32'hE1A0_3211);
      check("bp_resume0_pc", bus_a.pc_d, 32'h8);
      check("bp_resume0_valid", {31'd0, bus_a.valid_d}, 32'd1);
      tick();
      check("bp_resume1_instr", bus_a.instr_d, 32'hA000_000C);
      check("bp_resume1_pc", bus_a.pc_d, 32'hC);

      // redirect coinciding with a pop
      reset_n = 1'b0;
      tick();
      reset_n = 1'b1;
      tick();
      tick();
      check("rdp_pop_pc", bus_a.pc_d, 32'h4);
      check("rdp_pop_valid", {31'd0, bus_a.valid_d}, 32'd1);
      bus_a.redirect    = 1'b1;
      bus_a.redirect_pc = 32'h27;
      tick();
      bus_a.redirect = 1'b0;
      check("rdp_bubble_valid", {31'd0, bus_a.valid_d}, 32'd0);
      check("rdp_imem_a", bus_a.imem_a, 32'h24);
      check("rdp_count", {30'd0, count_a}, 32'd0);
      check("rdp_hold_pc", bus_a.pc_d, 32'h4);
      tick();
      check("rdp_target_valid", {31'd0, bus_a.valid_d}, 32'd1);
      check("rdp_target_pc", bus_a.pc_d, 32'h24);
      check("rdp_target_instr", bus_a.instr_d, 32'hA000_0024);
      check("rdp_target_pc8", bus_a.pcplus8_d, 32'h2C);

      // redirect with a full buffer
      bus_a.ready_d = 1'b0;
      tick();
      check("rdf_count_full", {30'd0, count_a}, 32'd2);
      check("rdf_imem_a_full", bus_a.imem_a, 32'h2C);
      bus_a.redirect    = 1'b1;
      bus_a.redirect_pc = 32'h40;
      tick();
      bus_a.redirect = 1'b0;
      check("rdf_count_flush", {30'd0, count_a}, 32'd0);
      check("rdf_valid_flush", {31'd0, bus_a.valid_d}, 32'd0);
      check("rdf_imem_a", bus_a.imem_a, 32'h40);
      tick();
      check("rdf_target_valid", {31'd0, bus_a.valid_d}, 32'd1);
      check("rdf_target_pc", bus_a.pc_d, 32'h40);
      check("rdf_target_instr", bus_a.instr_d, 32'hA000_0040);
      check("rdf_target_count", {30'd0, count_a}, 32'd1);

      // asynchronous reset between edges with the buffer full
      tick();
      check("ar_count_full", {30'd0, count_a}, 32'd2);
      #3;
      reset_n = 1'b0;
      #1;
      check("ar_valid", {31'd0, bus_a.valid_d}, 32'd0);
      check("ar_imem_a", bus_a.imem_a, 32'h0);
      check("ar_count", {30'd0, count_a}, 32'd0);
      check("ar_instr", bus_a.instr_d, 32'h0);
      check("ar_pc", bus_a.pc_d, 32'h0);
      check("ar_pc8", bus_a.pcplus8_d, 32'h8);
      tick();
      reset_n = 1'b1;

      // PC wrap on the second instance
      check("wrap_rst_imem_a", bus_b.imem_a, 32'hFFFF_FFF8);
      reset_n_b = 1'b1;
      tick();
      check("wrap0_pc", bus_b.pc_d, 32'hFFFF_FFF8);
      check("wrap0_instr", bus_b.instr_d, 32'hFFFF_FFF8);
      check("wrap0_valid", {31'd0, bus_b.valid_d}, 32'd1);
      tick();
      check("wrap1_pc", bus_b.pc_d, 32'hFFFF_FFFC);
      check("wrap1_pc8", bus_b.pcplus8_d, 32'h0000_0004);
      tick();
      check("wrap2_pc", bus_b.pc_d, 32'h0000_0000);
      check("wrap2_instr", bus_b.instr_d, 32'hE3A0_1002);
      check("wrap2_pc8", bus_b.pcplus8_d, 32'h0000_0008);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
      $finish;
   end

endmodule
